conv_img_feeder: RTL



---
 rtl/conv_img_feeder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/conv_img_feeder.sv
// Streams a zero-padded SIZE x SIZE frame from an unpadded IMG x IMG pixel RAM,
// one pixel per GAP-cycle slot, after a 3-cycle i_load preamble.
module conv_img_feeder #(
  parameter int IMG = 14,
  parameter int PAD = 1,
  parameter int DW  = 16,
  parameter int AW  = 8,
  parameter int GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          i_load,
  output logic [DW-1:0] img_in,
  output logic          pix_valid,
  output logic          busy,
  output logic          done
);

  localparam int SIZE = IMG + 2*PAD;
  localparam int CW   = $clog2(SIZE + 1);
  localparam int SW   = $clog2(GAP);

  localparam logic [CW-1:0] C_LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] C_PAD  = CW'(PAD);
  localparam logic [CW-1:0] C_IMG  = CW'(IMG);
  localparam logic [AW-1:0] A_IMG  = AW'(IMG);
  localparam logic [SW-1:0] S_LAST = SW'(GAP - 1);
  localparam logic [SW-1:0] S_CAP  = SW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_lcnt;
  logic [DW-1:0] r_img;
  logic [DW-1:0] r_next;
  logic [AW-1:0] r_addr_hold;
  logic          r_done;

  logic [CW-1:0] w_frow;
  logic [CW-1:0] w_fcol;
  logic [CW-1:0] w_rr;
  logic [CW-1:0] w_cc;
  logic          w_fint;
  logic [AW-1:0] w_faddr;
  logic [DW-1:0] w_cap;
  logic          w_slot_end;
  logic          w_last;

  // Fetch target: pixel 0 during LOAD, otherwise the pixel after the current one.
  // Pad rows/columns below PAD wrap to large values, so one "< IMG" test covers both borders.
  always_comb begin
    w_frow = r_row;
    w_fcol = r_col;
    if (r_state == STREAM) begin
      if (r_col == C_LAST) begin
        w_fcol = '0;
        w_frow = r_row + 1'b1;
      end else begin
        w_fcol = r_col + 1'b1;
      end
    end
    w_rr    = w_frow - C_PAD;
    w_cc    = w_fcol - C_PAD;
    w_fint  = (w_rr < C_IMG) && (w_cc < C_IMG);
    w_faddr = AW'(w_rr) * A_IMG + AW'(w_cc);
    w_cap   = w_fint ? rd_data : '0;
  end

  assign w_slot_end = (r_slot == S_LAST);
  assign w_last     = (r_row == C_LAST) && (r_col == C_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD;
      LOAD:    if (r_lcnt == 2'd2) w_state_nxt = STREAM;
      STREAM:  if (w_slot_end && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en     = 1'b0;
    i_load    = 1'b0;
    busy      = 1'b0;
    pix_valid = 1'b0;
    case (r_state)
      LOAD: begin
        i_load = 1'b1;
        busy   = 1'b1;
        rd_en  = (r_lcnt == 2'd0) && w_fint;
      end
      STREAM: begin
        busy      = 1'b1;
        pix_valid = (r_slot == '0);
        rd_en     = (r_slot == '0) && w_fint;
      end
      default: ;
    endcase
    rd_addr = rd_en ? w_faddr : r_addr_hold;
  end

  assign img_in = r_img;
  assign done   = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_slot      <= '0;
      r_lcnt      <= '0;
      r_img       <= '0;
      r_next      <= '0;
      r_addr_hold <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (rd_en) r_addr_hold <= w_faddr;
      case (r_state)
        IDLE: begin
          r_row  <= '0;
          r_col  <= '0;
          r_slot <= '0;
          r_lcnt <= '0;
        end
        LOAD: begin
          r_lcnt <= r_lcnt + 1'b1;
          if (r_lcnt == 2'd1) r_next <= w_cap;
          if (r_lcnt == 2'd2) begin
            r_img  <= r_next;
            r_lcnt <= '0;
          end
        end
        STREAM: begin
          if (r_slot == S_CAP) r_next <= w_cap;
          if (w_slot_end) begin
            r_slot <= '0;
            if (w_last) begin
              r_img  <= '0;
              r_done <= 1'b1;
              r_row  <= '0;
              r_col  <= '0;
            end else begin
              // With GAP=2 capture and slot end share a cycle, so bypass r_next.
              r_img <= (r_slot == S_CAP) ? w_cap : r_next;
              r_row <= w_frow;
              r_col <= w_fcol;
            end
          end else begin
            r_slot <= r_slot + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
